// File: rtl/dino_jump_controller.sv
// -----------------------------------------------------------------------------
// dino_jump_controller
//
// Per-frame vertical motion generator for the dino sprite. Integrates a
// fixed-point jump/gravity trajectory once per frame tick and presents the
// integer sprite row to the pixel renderer.
//
// Position is unsigned Q8.4 (12 bits), velocity signed Q3.4 (8 bits,
// negative = upward).
//
// Ports:
//   clk        in  1  system clock
//   reset      in  1  synchronous active-high reset
//   frameClk   in  1  one-clk-wide pulse per frame; motion advances only here
//   jump       in  1  jump button level, already synchronised to clk
//   gameState  in  4  game FSM state; motion runs only at GAME_RUNNING
//   dinoY      out 8  sprite top row (integer part of position), registered
//   airborne   out 1  high while the dino is in the AIR state
//   landed     out 1  one-cycle pulse on the tick the dino touches ground
// -----------------------------------------------------------------------------
module dino_jump_controller #(
  parameter int unsigned GROUND_Y     = 80,
  parameter int unsigned TOP_Y        = 8,
  parameter int unsigned JUMP_V0      = 56,
  parameter int unsigned GRAVITY      = 4,
  parameter int unsigned MAX_FALL     = 64,
  parameter logic [3:0]  GAME_RUNNING = 4'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frameClk,
  input  logic       jump,
  input  logic [3:0] gameState,
  output logic [7:0] dinoY,
  output logic       airborne,
  output logic       landed
);

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_GROUND = 2'd1,
    ST_AIR    = 2'd2
  } state_t;

  localparam logic [11:0] GROUND_Q4  = 12'(GROUND_Y * 16);
  localparam logic [11:0] TOP_Q4     = 12'(TOP_Y * 16);
  // Two's-complement of the launch speed, i.e. an upward velocity.
  localparam logic [7:0]  VEL_LAUNCH = 8'(256 - JUMP_V0);

  state_t      r_state;
  logic [11:0] r_pos;
  logic [7:0]  r_vel;
  logic        r_jump_prev;
  logic        r_pending;
  logic        r_airborne;
  logic        r_landed;

  logic               w_running;
  logic               w_edge;
  logic signed [12:0] w_next;
  logic signed [8:0]  w_vel_inc;
  logic [7:0]         w_vel_grav;

  assign w_running = (gameState == GAME_RUNNING);
  assign w_edge    = jump & ~r_jump_prev;

  // Candidate position in 13-bit signed so an upward step past row 0 shows up
  // as negative instead of wrapping to a large unsigned value.
  assign w_next = $signed({1'b0, r_pos}) + $signed({{5{r_vel[7]}}, r_vel});

  // Gravity step one bit wider than vel so the terminal-velocity compare
  // cannot be fooled by overflow.
  assign w_vel_inc  = $signed({r_vel[7], r_vel}) + $signed(9'(GRAVITY));
  assign w_vel_grav = (w_vel_inc > $signed(9'(MAX_FALL))) ? 8'(MAX_FALL)
                                                           : w_vel_inc[7:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_HOLD;
      r_pos       <= GROUND_Q4;
      r_vel       <= 8'd0;
      r_jump_prev <= 1'b0;
      r_pending   <= 1'b0;
      r_airborne  <= 1'b0;
      r_landed    <= 1'b0;
    end else begin
      r_jump_prev <= jump;
      r_landed    <= 1'b0;
      if (!w_running) begin
        // Freeze pos/vel so a game-over frame shows the dino where it stopped.
        r_state    <= ST_HOLD;
        r_pending  <= 1'b0;
        r_airborne <= 1'b0;
      end else begin
        case (r_state)
          ST_HOLD: begin
            r_pos      <= GROUND_Q4;
            r_vel      <= 8'd0;
            r_state    <= ST_GROUND;
            r_pending  <= 1'b0;
            r_airborne <= 1'b0;
          end
          ST_GROUND: begin
            if (frameClk) begin
              // An edge arriving on the tick itself launches immediately.
              if (r_pending || w_edge) begin
                r_vel      <= VEL_LAUNCH;
                r_state    <= ST_AIR;
                r_airborne <= 1'b1;
                r_pending  <= 1'b0;
              end
            end else if (w_edge) begin
              r_pending <= 1'b1;
            end
          end
          ST_AIR: begin
            if (frameClk) begin
              if (w_next >= $signed({1'b0, GROUND_Q4})) begin
                r_pos      <= GROUND_Q4;
                r_vel      <= 8'd0;
                r_state    <= ST_GROUND;
                r_airborne <= 1'b0;
                r_landed   <= 1'b1;
              end else if (w_next < $signed({1'b0, TOP_Q4})) begin
                // Ceiling hit: pin to the top row and start falling from rest.
                r_pos <= TOP_Q4;
                r_vel <= 8'd0;
              end else begin
                r_pos <= w_next[11:0];
                r_vel <= w_vel_grav;
              end
            end
          end
          default: begin
            r_state    <= ST_HOLD;
            r_airborne <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dinoY    = r_pos[11:4];
  assign airborne = r_airborne;
  assign landed   = r_landed;

endmodule

// File: tb/tb_dino_jump_controller.sv
// -----------------------------------------------------------------------------
// tb_dino_jump_controller
//
// Drives two controllers in lock-step from the same inputs: one with default
// parameters and one with TOP_Y=60 so the ceiling clamp is exercised. A
// reference model of the motion rules predicts both outputs each cycle; the
// prediction is queued when the stimulus is driven and popped when the DUT
// output for that cycle is sampled. Hand-computed trajectory checkpoints are
// checked on top of the model.
// -----------------------------------------------------------------------------
module tb_dino_jump_controller;

  localparam logic [3:0] RUN  = 4'd1;
  localparam logic [3:0] OVER = 4'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       frame_clk = 1'b0;
  logic       jump = 1'b0;
  logic [3:0] game_state = 4'd0;

  logic [7:0] y0, y1;
  logic       a0, a1, l0, l1;

  always #5 clk = ~clk;

  dino_jump_controller #(.GAME_RUNNING(RUN)) dut (
    .clk(clk), .reset(reset), .frameClk(frame_clk), .jump(jump),
    .gameState(game_state), .dinoY(y0), .airborne(a0), .landed(l0)
  );

  dino_jump_controller #(.TOP_Y(60), .GAME_RUNNING(RUN)) dut_top (
    .clk(clk), .reset(reset), .frameClk(frame_clk), .jump(jump),
    .gameState(game_state), .dinoY(y1), .airborne(a1), .landed(l1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: 0 HOLD, 1 GROUND, 2 AIR. Index 0 default, 1 top=60.
  int m_state[2];
  int m_pos[2];
  int m_vel[2];
  bit m_prev[2];
  bit m_pend[2];
  bit m_land[2];
  int m_top[2];

  typedef struct {
    int y0; bit a0; bit l0;
    int y1; bit a1; bit l1;
  } exp_t;
  exp_t sb[$];

  int land_cnt[2];
  int f_first[2];
  int f_peak[2];
  int f_land[2];

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_update(input bit rst, input logic [3:0] gs,
                              input bit jmp, input bit tick);
    for (int i = 0; i < 2; i++) begin
      bit jedge;
      jedge = jmp && !m_prev[i];
      if (rst) begin
        m_state[i] = 0; m_pos[i] = 1280; m_vel[i] = 0;
        m_prev[i] = 0; m_pend[i] = 0; m_land[i] = 0;
      end else begin
        m_prev[i] = jmp;
        m_land[i] = 0;
        if (gs != RUN) begin
          m_state[i] = 0;
          m_pend[i] = 0;
        end else if (m_state[i] == 0) begin
          m_pos[i] = 1280; m_vel[i] = 0; m_state[i] = 1; m_pend[i] = 0;
        end else if (m_state[i] == 1) begin
          if (tick) begin
            if (m_pend[i] || jedge) begin
              m_vel[i] = -56; m_state[i] = 2; m_pend[i] = 0;
            end
          end else if (jedge) begin
            m_pend[i] = 1;
          end
        end else if (tick) begin
          int n;
          n = m_pos[i] + m_vel[i];
          if (n >= 1280) begin
            m_pos[i] = 1280; m_vel[i] = 0; m_state[i] = 1; m_land[i] = 1;
          end else if (n < m_top[i]) begin
            m_pos[i] = m_top[i]; m_vel[i] = 0;
          end else begin
            m_pos[i] = n;
            m_vel[i] = (m_vel[i] + 4 > 64) ? 64 : m_vel[i] + 4;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, queue the prediction, clock, then compare.
  task automatic step(input bit rst, input logic [3:0] gs,
                      input bit jmp, input bit tick);
    exp_t e;
    reset = rst; game_state = gs; jump = jmp; frame_clk = tick;
    model_update(rst, gs, jmp, tick);
    e.y0 = m_pos[0] / 16; e.a0 = (m_state[0] == 2); e.l0 = m_land[0];
    e.y1 = m_pos[1] / 16; e.a1 = (m_state[1] == 2); e.l1 = m_land[1];
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    $display("t=%0t rst=%0b gs=%0d jmp=%0b tick=%0b | y=%0d/%0d air=%0b/%0b land=%0b/%0b",
             $time, rst, gs, jmp, tick, y0, y1, a0, a1, l0, l1);
    n_vec++;
    if (y0 != e.y0 || a0 != e.a0 || l0 != e.l0) begin
      n_err++;
      $display("FAIL sb_default: got y=%0d air=%0b land=%0b, expected y=%0d air=%0b land=%0b",
               y0, a0, l0, e.y0, e.a0, e.l0);
    end
    n_vec++;
    if (y1 != e.y1 || a1 != e.a1 || l1 != e.l1) begin
      n_err++;
      $display("FAIL sb_top60: got y=%0d air=%0b land=%0b, expected y=%0d air=%0b land=%0b",
               y1, a1, l1, e.y1, e.a1, e.l1);
    end
    land_cnt[0] += int'(l0);
    land_cnt[1] += int'(l1);
  endtask

  // Flight: repeated {idle cycle, tick cycle} until the default DUT lands.
  // jmode 0: jump low; 1: jump held high; 2: pulsed high on idle cycles.
  task automatic flight(input int jmode);
    f_first = '{-1, -1};
    f_peak  = '{255, 255};
    f_land  = '{-1, -1};
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, RUN, (jmode != 0), 1'b0);
      step(1'b0, RUN, (jmode == 1), 1'b1);
      if (k == 1) begin f_first[0] = int'(y0); f_first[1] = int'(y1); end
      if (int'(y0) < f_peak[0]) f_peak[0] = int'(y0);
      if (int'(y1) < f_peak[1]) f_peak[1] = int'(y1);
      if (l1 && f_land[1] < 0) f_land[1] = k;
      if (l0 && f_land[0] < 0) f_land[0] = k;
      if (f_land[0] >= 0) break;
    end
  endtask

  typedef struct {
    bit rst; logic [3:0] gs; bit jmp; bit tick;
    int y; bit a; bit l;
  } vec_t;
  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    m_top[0] = 128;
    m_top[1] = 960;
    for (int i = 0; i < 2; i++) begin
      m_state[i] = 0; m_pos[i] = 1280; m_vel[i] = 0;
      m_prev[i] = 0; m_pend[i] = 0; m_land[i] = 0;
    end

    // Reset, idle game, then running with no jump for 10 ticks.
    tbl.push_back('{1'b1, 4'd0, 1'b0, 1'b0, 80, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'd0, 1'b0, 1'b1, 80, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OVER, 1'b0, 1'b1, 80, 1'b0, 1'b0});
    tbl.push_back('{1'b0, OVER, 1'b0, 1'b0, 80, 1'b0, 1'b0});
    tbl.push_back('{1'b0, RUN,  1'b0, 1'b0, 80, 1'b0, 1'b0});
    for (int k = 0; k < 10; k++) begin
      tbl.push_back('{1'b0, RUN, 1'b0, 1'b1, 80, 1'b0, 1'b0});
      tbl.push_back('{1'b0, RUN, 1'b0, 1'b0, 80, 1'b0, 1'b0});
    end

    @(negedge clk);
    land_cnt = '{0, 0};
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].gs, tbl[i].jmp, tbl[i].tick);
      chk("tbl_y", int'(y0), tbl[i].y);
      chk("tbl_air", int'(a0), int'(tbl[i].a));
      chk("tbl_land", int'(l0), int'(tbl[i].l));
    end
    chk("ground_no_landed", land_cnt[0], 0);

    // Jump edge between ticks, full default trajectory; TOP_Y=60 clamps.
    step(1'b0, RUN, 1'b1, 1'b0);
    step(1'b0, RUN, 1'b0, 1'b0);
    land_cnt = '{0, 0};
    step(1'b0, RUN, 1'b0, 1'b1);
    chk("t0_air", int'(a0), 1);
    chk("t0_y", int'(y0), 80);
    chk("t0_air_top", int'(a1), 1);
    flight(0);
    chk("t1_y", f_first[0], 76);
    chk("peak_y", f_peak[0], 53);
    chk("land_tick", f_land[0], 29);
    chk("land_y", int'(y0), 80);
    chk("land_air", int'(a0), 0);
    chk("land_pulse", int'(l0), 1);
    chk("top_clamp_y", f_peak[1], 60);
    chk("top_land_tick", f_land[1], 22);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, RUN, 1'b0, 1'b0);
      step(1'b0, RUN, 1'b0, 1'b1);
    end
    chk("stay_ground_air", int'(a0), 0);
    chk("stay_ground_y", int'(y0), 80);
    chk("single_landed", land_cnt[0], 1);
    chk("single_landed_top", land_cnt[1], 1);

    // Edge coincident with a tick; hold jump high through landing.
    step(1'b0, RUN, 1'b1, 1'b1);
    chk("coinc_air", int'(a0), 1);
    flight(1);
    chk("coinc_peak", f_peak[0], 53);
    chk("coinc_land", f_land[0], 29);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, RUN, 1'b1, 1'b0);
      step(1'b0, RUN, 1'b1, 1'b1);
    end
    chk("held_no_relaunch", int'(a0), 0);
    step(1'b0, RUN, 1'b0, 1'b0);
    step(1'b0, RUN, 1'b1, 1'b1);
    chk("repress_launch", int'(a0), 1);

    // Edges while airborne are ignored; trajectory unchanged.
    flight(2);
    chk("air_edges_peak", f_peak[0], 53);
    chk("air_edges_land", f_land[0], 29);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, RUN, 1'b0, 1'b0);
      step(1'b0, RUN, 1'b0, 1'b1);
    end
    chk("after_air_edges_ground", int'(a0), 0);

    // Freeze mid-jump when the game leaves the running state.
    step(1'b0, RUN, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, RUN, 1'b0, 1'b0);
      step(1'b0, RUN, 1'b0, 1'b1);
    end
    chk("pre_freeze_y", int'(y0), 65);
    step(1'b0, OVER, 1'b0, 1'b1);
    chk("freeze_y", int'(y0), 65);
    chk("freeze_air", int'(a0), 0);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, OVER, 1'b1, 1'b0);
      step(1'b0, OVER, 1'b0, 1'b1);
    end
    chk("frozen_y", int'(y0), 65);
    step(1'b0, RUN, 1'b0, 1'b0);
    chk("resume_y", int'(y0), 80);
    chk("resume_air", int'(a0), 0);
    step(1'b0, RUN, 1'b0, 1'b1);
    chk("resume_ground", int'(a0), 0);

    // Reset mid-jump.
    step(1'b0, RUN, 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) begin
      step(1'b0, RUN, 1'b0, 1'b0);
      step(1'b0, RUN, 1'b0, 1'b1);
    end
    chk("pre_reset_air", int'(a0), 1);
    step(1'b1, RUN, 1'b0, 1'b1);
    chk("reset_y", int'(y0), 80);
    chk("reset_air", int'(a0), 0);
    step(1'b0, RUN, 1'b0, 1'b1);
    step(1'b0, RUN, 1'b1, 1'b0);
    step(1'b0, RUN, 1'b1, 1'b1);
    chk("post_reset_launch", int'(a0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dino_jump_controller.md
# dino_jump_controller

Per-frame vertical motion generator for the dino sprite. Consumes the player jump button and the frame tick, integrates a fixed-point jump/gravity trajectory, and produces the registered `dinoY` row that the pixel renderer reads for every pixel of the next frame. Sits directly upstream of the pixel renderer, alongside the obstacle logic, in the game datapath.

## Interface
Parameters:
- `GROUND_Y`, 80: dinoY (top row of sprite) when standing; equals groundTop − dinoH.
- `TOP_Y`, 8: minimum allowed dinoY (ceiling).
- `JUMP_V0`, 56: launch speed magnitude, Q3.4 px/frame (3.5 px/frame).
- `GRAVITY`, 4: velocity increment per tick, Q3.4 (0.25 px/frame²).
- `MAX_FALL`, 64: maximum downward velocity, Q3.4 (4 px/frame).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `frameClk` in 1: one-`clk`-wide pulse per frame; all motion updates happen only on this tick.
- `jump` in 1: jump button level, already synchronised to `clk`.
- `gameState` in 4: game FSM state; motion runs only when equal to `GAME_RUNNING`.
- `dinoY` out 8: sprite top row, registered, integer part of position.
- `airborne` out 1: high while state is AIR.
- `landed` out 1: one-cycle pulse on the tick the dino touches ground.

## Operation
- Internal: `pos` 12-bit unsigned Q8.4; `vel` 8-bit signed Q3.4 (negative = upward); `jumpPrev`, `pending` flags; state ∈ {HOLD, GROUND, AIR}.
- `dinoY` = `pos[11:4]` (truncate fraction).
- Jump edge = `jump & ~jumpPrev`. `pending` is set by an edge only in GROUND. Edges in HOLD/AIR are discarded, with no buffering. `pending` is cleared on launch and on any exit from GROUND.
- HOLD (gameState ≠ `GAME_RUNNING`): `pos`, `vel` frozen, so a game-over frame shows the dino where it stopped. `landed`=0. On the first cycle with gameState = `GAME_RUNNING`: `pos`←GROUND_Y<<4, `vel`←0, go to GROUND.
- Any state with gameState ≠ `GAME_RUNNING` → HOLD on the next cycle, including mid-jump.
- GROUND, tick, launch = `pending | edge` (an edge coincident with the tick counts): `vel`←−JUMP_V0, go to AIR, `pos` unchanged this tick.
- AIR, tick: compute `next` = `pos` + sign-extended `vel` in 13-bit signed.
  - If `next` ≥ GROUND_Y<<4: `pos`←GROUND_Y<<4, `vel`←0, go to GROUND, pulse `landed`.
  - Else if `next` < TOP_Y<<4: `pos`←TOP_Y<<4, `vel`←0, stay AIR.
  - Else: `pos`←`next`, `vel`←min(`vel`+GRAVITY, MAX_FALL) with the compare done signed.
- Non-tick cycles: only `jumpPrev` and `pending` update.

## Timing
- Reset values: state HOLD, `pos`=GROUND_Y<<4, `dinoY`=GROUND_Y, `vel`=0, `airborne`=0, `landed`=0, `pending`=0, `jumpPrev`=0.
- All outputs are registered. A tick at cycle n produces new `dinoY`/`airborne`/`landed` at cycle n+1.
- `dinoY` changes only the cycle after a tick, or after HOLD→GROUND. It is stable for the whole frame the renderer scans.
- With default parameters the trajectory is exactly symmetric:
  - Launch tick T0 sets `vel`=−56.
  - Ticks T1..T14 rise 420 Q4 units. The peak is `pos`=860, `dinoY`=53, after T14.
  - Ticks T15..T29 fall back. T29 lands exactly on GROUND_Y, `landed` pulses, and `airborne` drops.
- Reset takes priority over everything. Reset mid-jump returns to HOLD/ground values next cycle.

## Test plan
- Reset, then gameState=`GAME_RUNNING`, no jump, 10 ticks -> `dinoY`=80 constant, `airborne`=0, `landed` never pulses.
- Jump edge between ticks, defaults -> `airborne`=1 after T0. `dinoY` after T1=76 (1280−56=1224), peak 53 after T14, 80 after T29 with a single `landed` pulse. 30 ticks in total.
- Jump edge in the same cycle as a tick -> launch on that tick, identical trajectory. Holding `jump` high through landing -> no relaunch until released and re-pressed.
- Jump edges while AIR -> ignored. Landing followed by no new edge -> stays GROUND.
- TOP_Y=60, defaults otherwise -> `dinoY` clamps at 60 (`vel`←0), then falls back and lands.
- gameState changes to a non-running value mid-jump -> `dinoY` frozen across ticks. Returning to `GAME_RUNNING` -> `dinoY`=80 next cycle, state GROUND. Assert `reset` mid-jump -> `dinoY`=80, `airborne`=0 next cycle.
